multicycle_adder: RTL and testbench

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

---
 rtl/multicycle_adder_pkg.sv | 15 +
 rtl/chunk_adder.sv | 27 ++
 rtl/multicycle_adder.sv | 117 +++++++++++
 tb/tb_multicycle_adder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_adder_pkg.sv
// Shared types for the multicycle adder: controller states and operation mode.
package multicycle_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_t;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder slice; also exposes the carry into its MSB.
module chunk_adder #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout  = carry[CHUNK];
    c_msb = carry[CHUNK-1];
  end

endmodule

// File: rtl/multicycle_adder.sv
// Add/subtract unit processing CHUNK bits per clock with valid/ready handshakes
// on both operand and result sides.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if ((CHUNK < 1) || ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_param_check
    $error("multicycle_adder: CHUNK must be >= 1 and divide WIDTH");
  end

  localparam int unsigned N     = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic               carry_q, cout_q, ovf_q;
  logic [IDX_W-1:0]   idx_q;
  logic               accept, step, last;
  mode_t              mode;
  logic [CHUNK-1:0]   a_c, b_c, s_c;
  logic               c_out, c_msb;

  assign mode = sub ? MODE_SUB : MODE_ADD;
  assign last = (idx_q == IDX_W'(N - 1));
  assign a_c  = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_c  = b_q[int'(idx_q)*CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_c),
    .b     (b_c),
    .cin   (carry_q),
    .sum   (s_c),
    .cout  (c_out),
    .c_msb (c_msb)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is a + ~b + ~cin, so cout reads as "no borrow".
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= (mode == MODE_SUB) ? ~b : b;
      carry_q <= (mode == MODE_SUB) ? ~cin : cin;
      idx_q   <= '0;
    end else if (step) begin
      sum_q[int'(idx_q)*CHUNK +: CHUNK] <= s_c;
      carry_q <= c_out;
      if (last) begin
        idx_q  <= '0;
        cout_q <= c_out;
        ovf_q  <= c_msb ^ c_out;
      end else begin
        idx_q  <= idx_q + IDX_W'(1);
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Randomized and directed checks of multicycle_adder (8/2 and 2/1 configurations)
// against an arithmetic reference model.
module tb_multicycle_adder;

  logic clk = 1'b0;
  logic reset;

  logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2, ovf2;
  logic [1:0] a2, b2, sum2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  multicycle_adder #(.WIDTH(2), .CHUNK(1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .sub(sub2), .out_valid(out_valid2),
    .out_ready(out_ready2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned result for sum/cout, signed for overflow.
  function automatic void model(input int w, input int a, input int b, input int cin,
                                input int sub, output int s, output int c, output int o);
    int m, sa, sb, u, r;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (sub != 0) begin
      u = a - b - cin;
      r = sa - sb - cin;
      c = (u >= 0) ? 1 : 0;
    end else begin
      u = a + b + cin;
      r = sa + sb + cin;
      c = (u >= m) ? 1 : 0;
    end
    s = u & (m - 1);
    o = (r < -(m / 2) || r > (m / 2 - 1)) ? 1 : 0;
  endfunction

  // Called at a negedge with dut8 idle; leaves it idle at a negedge.
  task automatic run8(input int a, input int b, input int cin, input int sub, input int hold);
    int es, ec, eo, lat;
    model(8, a, b, cin, sub, es, ec, eo);
    check("in_ready8_idle", in_ready8, 1);
    a8 = 8'(a); b8 = 8'(b); cin8 = 1'(cin); sub8 = 1'(sub);
    in_valid8 = 1'b1;
    out_ready8 = (hold == 0);
    @(negedge clk);
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid8 = 1'b0;
    check("latency8", lat, 4);
    check("sum8", sum8, es);
    check("cout8", cout8, ec);
    check("ovf8", ovf8, eo);
    for (int i = 0; i < hold; i++) begin
      in_valid8 = 1'b1;
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
      check("hold_out_valid8", out_valid8, 1);
      check("hold_in_ready8", in_ready8, 0);
      check("hold_sum8", sum8, es);
      check("hold_cout8", cout8, ec);
      check("hold_ovf8", ovf8, eo);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(negedge clk);
    check("post_hs_out_valid8", out_valid8, 0);
    check("post_hs_in_ready8", in_ready8, 1);
    out_ready8 = 1'b0;
  endtask

  initial begin
    int es, ec, eo, lat, t;
    reset = 1'b1;
    in_valid8 = 0; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0; out_ready8 = 0;
    in_valid2 = 0; a2 = '0; b2 = '0; cin2 = 0; sub2 = 0; out_ready2 = 1;
    repeat (3) @(negedge clk);
    check("rst_sum8", sum8, 0);
    check("rst_cout8", cout8, 0);
    check("rst_ovf8", ovf8, 0);
    check("rst_out_valid8", out_valid8, 0);
    check("rst_out_valid2", out_valid2, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready8", in_ready8, 1);
    check("rst_in_ready2", in_ready2, 1);

    run8(8'hFF, 8'h01, 0, 0, 0);
    run8(8'h7F, 8'h01, 0, 0, 2);
    run8(8'h05, 8'h07, 0, 1, 5);
    run8(8'h80, 8'h01, 1, 1, 1);
    for (int i = 0; i < 24; i++)
      run8($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 3));

    // Abort mid-operation: reset lands on the edge that would process chunk 2.
    a8 = 8'h3C; b8 = 8'h55; cin8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_out_valid8", out_valid8, 0);
    check("abort_sum8", sum8, 0);
    check("abort_cout8", cout8, 0);
    check("abort_ovf8", ovf8, 0);
    check("abort_in_ready8", in_ready8, 1);
    reset = 1'b0;
    @(negedge clk);
    run8(8'h3C, 8'h55, 1, 0, 0);

    // Exhaustive 2-bit configuration, back-to-back with out_ready held high.
    for (int k = 0; k < 64; k++) begin
      model(2, k & 3, (k >> 2) & 3, (k >> 4) & 1, (k >> 5) & 1, es, ec, eo);
      a2 = 2'(k); b2 = 2'(k >> 2); cin2 = 1'(k >> 4); sub2 = 1'(k >> 5);
      in_valid2 = 1'b1;
      t = 0;
      while (!in_ready2 && t < 10) begin
        @(negedge clk);
        t++;
      end
      check("ex_accept2", in_ready2, 1);
      @(negedge clk);
      in_valid2 = 1'b0;
      lat = 0;
      while (!out_valid2 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      check("ex_latency2", lat, 2);
      check("ex_sum2", sum2, es);
      check("ex_cout2", cout2, ec);
      check("ex_ovf2", ovf2, eo);
    end
    @(negedge clk);
    check("ex_final_idle2", in_ready2, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
